// File: rtl/lzw_string_unwind.sv
// LZW string unwinder: walks a code's prefix chain back to its root character,
// stacking characters on the way, then streams them out first character first.
module lzw_string_unwind #(
    parameter int unsigned STACK_DEPTH = 4096,
    parameter int unsigned STACK_AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_code,
    output logic        pc_en,
    output logic [11:0] pc_addr,
    input  logic [12:0] pc_rd_data,
    output logic        ac_en,
    output logic [11:0] ac_addr,
    input  logic [7:0]  ac_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_char,
    output logic        out_last,
    output logic [7:0]  first_char,
    output logic        err
);

    localparam int unsigned CODE_W = 12;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned SP_W   = STACK_AW + 1;

    localparam logic [CODE_W-1:0] ROOT_LIM = CODE_W'(256);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, ROOT, POP} state_t;

    state_t              state, state_n;
    logic [SP_W-1:0]     sp, sp_n;
    logic [CODE_W-1:0]   cur, cur_n;
    logic                push_en;
    logic [CHAR_W-1:0]   push_data;
    logic                err_n;
    logic [CHAR_W-1:0]   first_n;
    logic [CHAR_W-1:0]   char_n;
    logic [STACK_AW-1:0] rd_idx;
    logic [CHAR_W-1:0]   stack [STACK_DEPTH];

    // Next-state, stack push and next output values
    always_comb begin
        state_n   = state;
        sp_n      = sp;
        cur_n     = cur;
        push_en   = 1'b0;
        push_data = cur[CHAR_W-1:0];
        err_n     = 1'b0;
        first_n   = first_char;
        char_n    = out_char;
        rd_idx    = '0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cur_n   = in_code;
                    state_n = (in_code < ROOT_LIM) ? ROOT : READ;
                end
            end
            READ: state_n = WAIT;
            WAIT: begin
                if (pc_rd_data[12] || (sp == SP_FULL)) begin
                    err_n   = 1'b1;
                    sp_n    = '0;
                    state_n = IDLE;
                end else begin
                    push_en   = 1'b1;
                    push_data = ac_rd_data;
                    sp_n      = sp + SP_ONE;
                    cur_n     = pc_rd_data[CODE_W-1:0];
                    state_n   = (cur_n < ROOT_LIM) ? ROOT : READ;
                end
            end
            ROOT: begin
                if (sp == SP_FULL) begin
                    err_n   = 1'b1;
                    sp_n    = '0;
                    state_n = IDLE;
                end else begin
                    push_en = 1'b1;
                    sp_n    = sp + SP_ONE;
                    first_n = cur[CHAR_W-1:0];
                    state_n = POP;
                end
            end
            POP: begin
                if (out_ready) begin
                    sp_n = sp - SP_ONE;
                    if (sp == SP_ONE) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Top of stack as it will be next cycle; the root char bypasses the array
        rd_idx = STACK_AW'(sp_n - SP_ONE);
        if (state_n == POP) begin
            char_n = (state == ROOT) ? cur[CHAR_W-1:0] : stack[rd_idx];
        end
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sp         <= '0;
            cur        <= '0;
            in_ready   <= 1'b1;
            pc_en      <= 1'b0;
            pc_addr    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_char   <= '0;
            first_char <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            sp         <= sp_n;
            cur        <= cur_n;
            in_ready   <= (state_n == IDLE);
            pc_en      <= (state_n == READ);
            if (state_n == READ) pc_addr <= cur_n;
            out_valid  <= (state_n == POP);
            out_last   <= (state_n == POP) && (sp_n == SP_ONE);
            out_char   <= char_n;
            first_char <= first_n;
            err        <= err_n;
        end
    end

    // Character LIFO storage
    always_ff @(posedge clk) begin
        if (push_en) stack[STACK_AW'(sp)] <= push_data;
    end

    assign ac_en   = pc_en;
    assign ac_addr = pc_addr;

endmodule
